mem_access_unit: RTL and testbench

Memory-stage load/store unit that produces mem_data_WB, the load-data input consumed by the writeback select. It issues word-aligned requests on a ready/valid data-memory bus and generates byte enables and lane-replicated store data. It extracts and sign/zero-extends load data and stalls the pipeline while an access is outstanding. A watchdog flags accesses that never complete.

---
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues word-aligned requests on a ready/valid
// data-memory bus, steers store lanes, extracts and extends load data, stalls
// the pipeline while an access is in flight, and faults hung accesses.
module mem_access_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] alu_result_MEM,
  input  logic [31:0] store_data_MEM,
  output logic        stall_MEM,
  output logic        mem_exc_MEM,
  output logic [31:0] mem_data_WB,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Last cycle an access may spend in REQ+WAIT before it is declared hung.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] wdog;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;

  logic        access, bad_f3, misal, fault, go, wd_hit;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Decode legality and alignment of the instruction sitting in MEM.
  always_comb begin
    access = mem_read_MEM ^ mem_write_MEM;
    bad_f3 = (funct3_MEM == 3'b011) || (funct3_MEM[2] && funct3_MEM[1]) ||
             (mem_write_MEM && funct3_MEM[2]);
    misal  = ((funct3_MEM[1:0] == 2'b01) && alu_result_MEM[0]) ||
             ((funct3_MEM[1:0] == 2'b10) && (alu_result_MEM[1:0] != 2'b00));
    fault  = (mem_read_MEM && mem_write_MEM) || (access && (bad_f3 || misal));
    go     = access && !bad_f3 && !misal;
    wd_hit = (TIMEOUT > 0) && (wdog == WD_LAST);
  end

  // Stall from the issuing IDLE cycle through REQ/WAIT; DONE releases the pipe.
  always_comb begin
    stall_MEM = ((state == IDLE) && go) || (state == REQ) || (state == WAIT);
  end

  // Byte enables and lane-replicated write data; loads read the full word.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = 32'h0;
    if (mem_write_MEM) begin
      case (funct3_MEM[1:0])
        2'b00: begin
          be_n    = 4'b0001 << alu_result_MEM[1:0];
          wdata_n = {4{store_data_MEM[7:0]}};
        end
        2'b01: begin
          be_n    = alu_result_MEM[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{store_data_MEM[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = store_data_MEM;
        end
      endcase
    end
  end

  // Pick the addressed lane of the returned word and extend it.
  always_comb begin
    ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  // Access sequencer with registered bus outputs, fault pulse and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wdog        <= '0;
      f3_q        <= 3'b0;
      lane_q      <= 2'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= 32'h0;
      mem_data_WB <= 32'h0;
      mem_exc_MEM <= 1'b0;
    end else begin
      mem_exc_MEM <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (go) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_MEM;
            dmem_addr  <= {alu_result_MEM[31:2], 2'b00};
            dmem_be    <= be_n;
            dmem_wdata <= wdata_n;
            f3_q       <= funct3_MEM;
            lane_q     <= alu_result_MEM[1:0];
            state      <= REQ;
          end else if (fault) begin
            mem_exc_MEM <= 1'b1;
          end
        end
        REQ: begin
          // Acceptance wins over a watchdog expiring in the same cycle.
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            wdog     <= wdog + 1'b1;
            state    <= dmem_we ? DONE : WAIT;
          end else if (wd_hit) begin
            dmem_req    <= 1'b0;
            mem_exc_MEM <= 1'b1;
            wdog        <= '0;
            state       <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            mem_data_WB <= ld_val;
            wdog        <= '0;
            state       <= DONE;
          end else if (wd_hit) begin
            mem_exc_MEM <= 1'b1;
            wdog        <= '0;
            state       <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          wdog  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: the driver plays both the pipeline and
// the memory, pushing expected bus/fault/completion events into a queue that a
// negedge monitor pops and compares as the DUT produces them.
module tb_mem_access_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_MEM = 0, mem_write_MEM = 0;
  logic [2:0]  funct3_MEM = 0;
  logic [31:0] alu_result_MEM = 0, store_data_MEM = 0;
  logic        stall_MEM, mem_exc_MEM, dmem_req, dmem_we;
  logic [31:0] mem_data_WB, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 0, dmem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read_MEM(mem_read_MEM), .mem_write_MEM(mem_write_MEM),
    .funct3_MEM(funct3_MEM), .alu_result_MEM(alu_result_MEM),
    .store_data_MEM(store_data_MEM),
    .stall_MEM(stall_MEM), .mem_exc_MEM(mem_exc_MEM), .mem_data_WB(mem_data_WB),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef enum {EV_BUS, EV_BUSTO, EV_EXC, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    int          stall;
  } ev_t;

  ev_t         q[$];
  ev_t         ev;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_load = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected DUT event at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  bit          prev_stall = 0, prev_req = 0;
  int          stall_run = 0;
  logic [31:0] wb_ref = 32'h0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0; prev_req = 0; stall_run = 0; wb_ref = 32'h0;
    end else begin
      if (stall_MEM) stall_run++;
      if (dmem_req) begin
        if (q.size() == 0 || !(q[0].kind inside {EV_BUS, EV_BUSTO})) fail("unexpected_req");
        else begin
          check("req_we",    {31'h0, dmem_we}, {31'h0, q[0].we});
          check("req_addr",  dmem_addr, q[0].addr);
          check("req_be",    {28'h0, dmem_be}, {28'h0, q[0].be});
          check("req_wdata", dmem_wdata, q[0].wdata);
          if (dmem_ready) begin
            if (q[0].kind == EV_BUS) void'(q.pop_front());
            else fail("ready_on_hung_req");
          end
        end
      end else if (prev_req && q.size() > 0 && q[0].kind == EV_BUSTO) begin
        void'(q.pop_front());
      end
      if (mem_exc_MEM) begin
        if (q.size() == 0 || q[0].kind != EV_EXC) fail("unexpected_exc");
        else begin
          check("exc_no_stall", {31'h0, stall_MEM}, 32'h0);
          check("exc_no_req",   {31'h0, dmem_req}, 32'h0);
          void'(q.pop_front());
        end
      end
      if (prev_stall && !stall_MEM) begin
        if (q.size() == 0 || q[0].kind != EV_DONE) fail("unexpected_done");
        else begin
          ev = q.pop_front();
          check("done_data",  mem_data_WB, ev.data);
          check("stall_len",  32'(stall_run), 32'(ev.stall));
          wb_ref = ev.data;
        end
        stall_run = 0;
      end else begin
        check("wb_hold", mem_data_WB, wb_ref);
      end
      prev_stall = stall_MEM;
      prev_req   = dmem_req;
    end
  end

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz = acc_size(f3);
    logic [31:0] v = rd >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_MEM = 0; mem_write_MEM = 0; funct3_MEM = 0;
    alu_result_MEM = 0; store_data_MEM = 0;
  endtask

  // hang: 0 normal, 1 never ready, 2 ready but never rvalid
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat,
                        input int rdly, input int vdly, input int hang);
    int  sz = acc_size(f3);
    bit  misal, flt;
    ev_t e;
    misal = (sz != 0) && ((a % sz) != 0);
    flt   = (rd && wr) || ((rd || wr) && (sz == 0 || (f3[2] && (wr || sz == 4)) || misal));
    tick();
    mem_read_MEM = rd; mem_write_MEM = wr; funct3_MEM = f3;
    alu_result_MEM = a; store_data_MEM = sd;
    if (!rd && !wr) return;
    if (flt) begin
      e = '{kind: EV_EXC, we: 0, addr: 0, be: 0, wdata: 0, data: 0, stall: 0};
      q.push_back(e);
      tick();
      idle_inputs();
      return;
    end
    if (wr && hang == 2) hang = 0;
    e.kind  = hang == 1 ? EV_BUSTO : EV_BUS;
    e.we    = wr;
    e.addr  = a & 32'hFFFF_FFFC;
    e.be    = wr ? 4'(((1 << sz) - 1) << (a % 4)) : 4'hF;
    e.wdata = !wr ? 32'h0 : sz == 1 ? sd[7:0] * 32'h0101_0101 :
              sz == 2 ? sd[15:0] * 32'h0001_0001 : sd;
    e.data  = 0;
    e.stall = 0;
    q.push_back(e);
    if (hang != 0) begin
      e = '{kind: EV_EXC, we: 0, addr: 0, be: 0, wdata: 0, data: 0, stall: 0};
      q.push_back(e);
    end
    e.kind  = EV_DONE;
    if (hang == 0 && !wr) last_load = load_model(f3, a, rdat);
    e.data  = last_load;
    e.stall = hang != 0 ? 1 + TO : wr ? rdly + 2 : rdly + vdly + 3;
    q.push_back(e);
    tick();                                   // first REQ cycle
    if (hang == 1) begin
      for (int i = 0; i < TO; i++) begin
        dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
        tick();
      end
      dmem_rvalid = 0;
    end else begin
      for (int i = 0; i < rdly; i++) begin
        dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
        tick();
      end
      dmem_ready = 1; dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
      tick();
      dmem_ready = 0; dmem_rvalid = 0;
      if (!wr) begin
        if (hang == 2) begin
          for (int i = 0; i < TO - 1 - rdly; i++) tick();
        end else begin
          for (int i = 0; i < vdly; i++) begin
            dmem_rdata = $urandom;
            tick();
          end
          dmem_rvalid = 1; dmem_rdata = rdat;
          tick();
          dmem_rvalid = 0; dmem_rdata = $urandom;
        end
      end
    end
    idle_inputs();                            // DONE: pipeline advances
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   {31'h0, dmem_req}, 32'h0);
    check({tag, "_we"},    {31'h0, dmem_we}, 32'h0);
    check({tag, "_addr"},  dmem_addr, 32'h0);
    check({tag, "_be"},    {28'h0, dmem_be}, 32'h0);
    check({tag, "_wdata"}, dmem_wdata, 32'h0);
    check({tag, "_wb"},    mem_data_WB, 32'h0);
    check({tag, "_exc"},   {31'h0, mem_exc_MEM}, 32'h0);
    check({tag, "_stall"}, {31'h0, stall_MEM}, 32'h0);
  endtask

  task automatic reset_in_wait();
    ev_t e;
    tick();
    mem_read_MEM = 1; funct3_MEM = 3'b010; alu_result_MEM = 32'h100;
    e = '{kind: EV_BUS, we: 0, addr: 32'h100, be: 4'hF, wdata: 0, data: 0, stall: 0};
    q.push_back(e);
    tick();                                   // REQ
    dmem_ready = 1;
    tick();                                   // WAIT
    dmem_ready = 0;
    rst = 1;
    idle_inputs();
    #2;
    check_all_zero("rst_wait");
    dmem_rvalid = 1; dmem_rdata = 32'hAAAA_5555;
    tick();
    rst = 0;
    tick();
    dmem_rvalid = 0;
    tick();
    check_all_zero("post_rst");
    last_load = 32'h0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel, hang;
    bit          rd, wr;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;
    // directed cases
    run_op(1, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0, 0, 0);  // LW
    run_op(1, 0, 3'b000, 32'h103, 0, 32'h80FF_FF7F, 1, 1, 0);  // LB
    run_op(1, 0, 3'b100, 32'h103, 0, 32'h80FF_FF7F, 0, 2, 0);  // LBU
    run_op(1, 0, 3'b101, 32'h102, 0, 32'h80FF_FF7F, 2, 0, 0);  // LHU
    run_op(0, 1, 3'b000, 32'h201, 32'h1234_5678, 0, 4, 0, 0);  // SB, ready delayed
    run_op(0, 1, 3'b001, 32'h202, 32'hCAFE_F00D, 0, 0, 0, 0);  // SH upper
    run_op(0, 1, 3'b010, 32'h302, 32'h1111_2222, 0, 0, 0, 0);  // SW misaligned
    run_op(0, 1, 3'b011, 32'h300, 32'h1111_2222, 0, 0, 0, 0);  // illegal funct3
    run_op(1, 1, 3'b010, 32'h300, 0, 0, 0, 0, 0);              // read and write
    run_op(0, 1, 3'b100, 32'h300, 0, 0, 0, 0, 0);              // store with unsigned f3
    run_op(1, 0, 3'b001, 32'h101, 0, 0, 0, 0, 0);              // LH misaligned
    run_op(1, 0, 3'b010, 32'h400, 0, 0, 0, 0, 1);              // no ready: timeout
    run_op(1, 0, 3'b010, 32'h404, 0, 0, 1, 0, 2);              // no rvalid: timeout
    run_op(1, 0, 3'b010, 32'h408, 0, 32'h0BAD_F00D, 3, 2, 0);  // boundary budget
    reset_in_wait();
    // random traffic
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 11);
      rd  = (sel >= 2 && sel < 7) || sel == 1;
      wr  = sel >= 7 || sel == 1;
      f3  = 3'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) == 4 ? 3 : acc_size(f3) == 2 ? 1 : 0);
      hang = $urandom_range(0, 19) == 0 ? int'($urandom_range(1, 2)) : 0;
      run_op(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), hang);
    end
    tick(); tick(); tick();
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
